// File: rtl/click_classifier_if.sv
// -----------------------------------------------------------------------------
// click_classifier_if
// Purpose : bundles the pulse input, the valid/ready result handshake and the
//           status outputs of click_classifier.
// Signals :
//   i_pulse    one-cycle press pulse (one click per high cycle)
//   i_ready    consumer accepts the current result
//   o_valid    click group result available
//   o_count    clicks in the reported group (1..MAX_CLICKS)
//   o_ovf      reported group exceeded MAX_CLICKS
//   o_busy     a group is being gathered
//   o_drop_cnt saturating count of pulses lost while a result waited
// Modports: master = classifier side, slave = pulse source / result consumer.
// -----------------------------------------------------------------------------
interface click_classifier_if;
  logic       i_pulse;
  logic       i_ready;
  logic       o_valid;
  logic [2:0] o_count;
  logic       o_ovf;
  logic       o_busy;
  logic [7:0] o_drop_cnt;

  modport master (
    input  i_pulse,
    input  i_ready,
    output o_valid,
    output o_count,
    output o_ovf,
    output o_busy,
    output o_drop_cnt
  );

  modport slave (
    output i_pulse,
    output i_ready,
    input  o_valid,
    input  o_count,
    input  o_ovf,
    input  o_busy,
    input  o_drop_cnt
  );
endinterface

// File: rtl/click_classifier.sv
// -----------------------------------------------------------------------------
// click_classifier
// Purpose : groups debounced press pulses into click groups. A group closes
//           after GAP_CYCLES idle cycles following its last pulse; the click
//           count (saturating at MAX_CLICKS, with an overflow flag) is then
//           offered on a valid/ready handshake.
// Ports   :
//   i_clk  single clock, rising edge
//   i_rst  asynchronous active-high reset
//   bus    click_classifier_if.master (pulse in, result handshake, status)
// All outputs are decoded from registers only, so there is no combinational
// path from any input to any output.
// -----------------------------------------------------------------------------
module click_classifier #(
  parameter int GAP_CYCLES = 1000,  // 2..65535
  parameter int MAX_CLICKS = 7      // 1..7
) (
  input  logic               i_clk,
  input  logic               i_rst,
  click_classifier_if.master bus
);

  // The timer only has to hold GAP_CYCLES-2 (its last value before closing
  // the group), so $clog2(GAP_CYCLES) bits always suffice.
  localparam int             TW         = $clog2(GAP_CYCLES);
  localparam logic [TW-1:0]  TIMER_LAST = TW'(GAP_CYCLES - 2);
  localparam logic [TW-1:0]  TIMER_ONE  = TW'(1);
  localparam logic [2:0]     COUNT_MAX  = 3'(MAX_CLICKS);

  typedef enum logic [1:0] {
    IDLE,
    GATHER,
    REPORT
  } state_t;

  state_t        r_state,     w_state_next;
  logic [2:0]    r_count,     w_count_next;
  logic          r_ovf,       w_ovf_next;
  logic [TW-1:0] r_timer,     w_timer_next;
  logic [2:0]    r_out_count, w_out_count_next;
  logic          r_out_ovf,   w_out_ovf_next;
  logic [7:0]    r_drop_cnt,  w_drop_cnt_next;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_timer     <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
      r_drop_cnt  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_count     <= w_count_next;
      r_ovf       <= w_ovf_next;
      r_timer     <= w_timer_next;
      r_out_count <= w_out_count_next;
      r_out_ovf   <= w_out_ovf_next;
      r_drop_cnt  <= w_drop_cnt_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_count_next     = r_count;
    w_ovf_next       = r_ovf;
    w_timer_next     = r_timer;
    w_out_count_next = r_out_count;
    w_out_ovf_next   = r_out_ovf;
    w_drop_cnt_next  = r_drop_cnt;

    case (r_state)
      IDLE: begin
        if (bus.i_pulse) begin
          w_state_next = GATHER;
          w_count_next = 3'd1;
          w_ovf_next   = 1'b0;
          w_timer_next = '0;
        end
      end

      GATHER: begin
        // A pulse takes priority over the gap expiring in the same cycle.
        if (bus.i_pulse) begin
          w_timer_next = '0;
          if (r_count == COUNT_MAX) begin
            w_ovf_next = 1'b1;
          end else begin
            w_count_next = r_count + 3'd1;
          end
        end else if (r_timer == TIMER_LAST) begin
          // Timer would reach GAP_CYCLES-1 here: close the group so that
          // o_valid rises exactly GAP_CYCLES cycles after the last pulse.
          w_state_next     = REPORT;
          w_out_count_next = r_count;
          w_out_ovf_next   = r_ovf;
        end else begin
          w_timer_next = r_timer + TIMER_ONE;
        end
      end

      REPORT: begin
        if (bus.i_ready) begin
          if (bus.i_pulse) begin
            // The pulse arriving with the transfer opens the next group.
            w_state_next = GATHER;
            w_count_next = 3'd1;
            w_ovf_next   = 1'b0;
            w_timer_next = '0;
          end else begin
            w_state_next = IDLE;
            w_count_next = '0;
            w_timer_next = '0;
          end
        end else if (bus.i_pulse && (r_drop_cnt != 8'hFF)) begin
          w_drop_cnt_next = r_drop_cnt + 8'd1;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign bus.o_valid    = (r_state == REPORT);
  assign bus.o_busy     = (r_state == GATHER);
  assign bus.o_count    = r_out_count;
  assign bus.o_ovf      = r_out_ovf;
  assign bus.o_drop_cnt = r_drop_cnt;

endmodule

// File: doc/click_classifier.md
CLICK_CLASSIFIER -- requirements
Module: click_classifier

Interface
REQ-001 The block SHALL expose parameter GAP_CYCLES, default 1000, meaning idle cycles after the last pulse that close a click group (legal range 2..65535).
REQ-002 The block SHALL expose parameter MAX_CLICKS, default 7, meaning the saturation value of the click count (legal range 1..7).
REQ-003 i_clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-004 i_rst  input  1  reset, asynchronous and active-high.
REQ-005 i_pulse  input  1  one-cycle press pulse from the debouncer; each high cycle SHALL be one click.
REQ-006 o_valid  output  1  click group result available.
REQ-007 i_ready  input  1  consumer accepts result.
REQ-008 o_count  output  3  clicks in the group, 1..MAX_CLICKS.
REQ-009 o_ovf  output  1  the group exceeded MAX_CLICKS.
REQ-010 o_busy  output  1  a group is being gathered (state GATHER).
REQ-011 o_drop_cnt  output  8  saturating count of pulses lost while a result waited.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, GATHER, REPORT.
REQ-013 IDLE: a pulse SHALL set count=1, ovf=0, gap timer=0 and move to GATHER in the next cycle.
REQ-014 GATHER, pulse sampled: count SHALL increment, saturating at MAX_CLICKS; a pulse at MAX_CLICKS SHALL set ovf=1; timer SHALL clear to 0.
REQ-015 GATHER, no pulse: timer SHALL increment; on reaching GAP_CYCLES-1 the FSM SHALL move to REPORT with o_count/o_ovf latched.
REQ-016 A pulse in the same cycle the timer reaches GAP_CYCLES-1 SHALL be counted and restart the timer; the pulse wins.
REQ-017 Latency: with the last pulse sampled in cycle t and none in t+1..t+GAP_CYCLES-1, o_valid SHALL be high from cycle t+GAP_CYCLES.
REQ-018 REPORT: o_valid SHALL stay high with o_count/o_ovf stable until a cycle with o_valid and i_ready both high (transfer).
REQ-019 Transfer without a pulse SHALL return the FSM to IDLE, with o_valid low the next cycle.
REQ-020 Transfer with a pulse in the same cycle SHALL go to GATHER with count=1, timer=0; that pulse SHALL NOT be dropped.
REQ-021 A pulse in REPORT without transfer SHALL be discarded and SHALL increment o_drop_cnt, saturating at 255.
REQ-022 o_count, o_ovf outside REPORT SHALL hold the last reported values (0 after reset).
REQ-023 o_busy SHALL be high exactly in GATHER.
REQ-024 The timer SHALL be wide enough for GAP_CYCLES-1 and SHALL never wrap.
REQ-025 Combinational paths from inputs to outputs SHALL NOT exist.

Reset
REQ-026 While i_rst is high, outputs SHALL be: o_valid=0, o_count=0, o_ovf=0, o_busy=0, o_drop_cnt=0; state IDLE; timer and count 0.
REQ-027 Asserting i_rst mid-GATHER or mid-REPORT SHALL abandon the group immediately with no result emitted.
REQ-028 A pulse in the first cycle after i_rst deasserts SHALL be accepted as in IDLE.

Verification (GAP_CYCLES=16, MAX_CLICKS=7)
REQ-029 Single pulse at cycle 10, i_ready=1 -> o_valid high in cycle 26 only, o_count=1, o_ovf=0.
REQ-030 Three pulses 5 cycles apart, last at cycle 20 -> o_valid at cycle 36, o_count=3; o_busy high from 11 to 35.
REQ-031 Nine pulses 4 cycles apart -> o_count=7, o_ovf=1.
REQ-032 i_ready=0 after o_valid, then 3 pulses, then i_ready=1 -> o_count unchanged during the wait, o_drop_cnt=3, IDLE after transfer.
REQ-033 Pulse in the cycle timer=15, then in the transfer cycle -> first group counts it with latency restarted; new group starts with count=1.
REQ-034 i_rst asserted mid-GATHER with count=2 -> o_busy=0 asynchronously, no o_valid ever for that group.
